// File: rtl/bavul_kasa_if.sv
// rtl/bavul_kasa_if.sv - bag fee intake and coin payment signal bundle
interface bavul_kasa_if #(
    parameter int TOPLAM_W = 12
);
    logic                bitti;
    logic [7:0]          ucret;
    logic                yolcu_bitti;
    logic                para_gecerli;
    logic [7:0]          para;
    logic                iptal;
    logic [TOPLAM_W-1:0] toplam;
    logic [3:0]          bavul_sayisi;
    logic                odeme_bekle;
    logic [TOPLAM_W-1:0] para_ustu;
    logic                tamam;
    logic                iade;
    logic                hata;

    modport slave (
        input  bitti, ucret, yolcu_bitti, para_gecerli, para, iptal,
        output toplam, bavul_sayisi, odeme_bekle, para_ustu, tamam, iade, hata
    );

    modport master (
        output bitti, ucret, yolcu_bitti, para_gecerli, para, iptal,
        input  toplam, bavul_sayisi, odeme_bekle, para_ustu, tamam, iade, hata
    );
endinterface

// File: rtl/bavul_kasa.sv
// rtl/bavul_kasa.sv - sums one passenger's bag fees, collects coins, pays change or refunds
module bavul_kasa #(
    parameter int MAKS_BAVUL = 8,
    parameter int TOPLAM_W   = 12
) (
    input  logic        saat,
    input  logic        reset,
    bavul_kasa_if.slave kasa
);
    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        TOPLA = 3'd1,
        ODEME = 3'd2,
        SONUC = 3'd3,
        IADE  = 3'd4
    } durum_t;

    localparam logic [3:0] MAKS = 4'(MAKS_BAVUL);

    durum_t durum, durum_n;

    logic [TOPLAM_W-1:0] toplam_q, toplam_n;
    logic [TOPLAM_W-1:0] odenen_q, odenen_n;
    logic [TOPLAM_W-1:0] ustu_q, ustu_n;
    logic [3:0]          sayi_q, sayi_n;
    logic                bekle_q, bekle_n;
    logic                tamam_q, tamam_n;
    logic                iade_q, iade_n;
    logic                hata_q, hata_n;

    // One extra bit catches carry-out so both running sums can saturate.
    logic [TOPLAM_W:0]   toplam_top;
    logic [TOPLAM_W:0]   odenen_top;
    logic [TOPLAM_W-1:0] toplam_sat;
    logic [TOPLAM_W-1:0] odenen_sat;

    assign toplam_top = {1'b0, toplam_q} + (TOPLAM_W+1)'(kasa.ucret);
    assign odenen_top = {1'b0, odenen_q} + (TOPLAM_W+1)'(kasa.para);
    assign toplam_sat = toplam_top[TOPLAM_W] ? '1 : toplam_top[TOPLAM_W-1:0];
    assign odenen_sat = odenen_top[TOPLAM_W] ? '1 : odenen_top[TOPLAM_W-1:0];

    // State register; reset drops any transaction in flight.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_n;
        end
    end

    // Next state and next register values; pulses default low every cycle.
    always_comb begin
        durum_n  = durum;
        toplam_n = toplam_q;
        odenen_n = odenen_q;
        ustu_n   = ustu_q;
        sayi_n   = sayi_q;
        bekle_n  = bekle_q;
        tamam_n  = 1'b0;
        iade_n   = 1'b0;
        hata_n   = 1'b0;
        case (durum)
            BOSTA: begin
                if (kasa.bitti) begin
                    toplam_n = TOPLAM_W'(kasa.ucret);
                    sayi_n   = 4'd1;
                    durum_n  = TOPLA;
                end
            end
            TOPLA: begin
                // A bag arriving with yolcu_bitti is still counted.
                if (kasa.bitti) begin
                    if (sayi_q < MAKS) begin
                        toplam_n = toplam_sat;
                        sayi_n   = sayi_q + 4'd1;
                        hata_n   = toplam_top[TOPLAM_W];
                    end else begin
                        hata_n = 1'b1;
                    end
                end
                if (kasa.yolcu_bitti) begin
                    durum_n = ODEME;
                    bekle_n = 1'b1;
                end
            end
            ODEME: begin
                hata_n = kasa.bitti;
                if (kasa.iptal) begin
                    // Cancel beats a coin in the same cycle; that coin is not kept.
                    durum_n = IADE;
                    bekle_n = 1'b0;
                end else begin
                    if (kasa.para_gecerli) begin
                        odenen_n = odenen_sat;
                    end
                    // Also covers a zero total with no coin at all.
                    if (odenen_n >= toplam_q) begin
                        durum_n = SONUC;
                        bekle_n = 1'b0;
                    end
                end
            end
            SONUC: begin
                hata_n   = kasa.bitti;
                tamam_n  = 1'b1;
                ustu_n   = odenen_q - toplam_q;
                toplam_n = '0;
                odenen_n = '0;
                sayi_n   = 4'd0;
                durum_n  = BOSTA;
            end
            IADE: begin
                hata_n   = kasa.bitti;
                iade_n   = 1'b1;
                ustu_n   = odenen_q;
                toplam_n = '0;
                odenen_n = '0;
                sayi_n   = 4'd0;
                durum_n  = BOSTA;
            end
            default: begin
                durum_n = BOSTA;
            end
        endcase
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            toplam_q <= '0;
            odenen_q <= '0;
            ustu_q   <= '0;
            sayi_q   <= 4'd0;
            bekle_q  <= 1'b0;
            tamam_q  <= 1'b0;
            iade_q   <= 1'b0;
            hata_q   <= 1'b0;
        end else begin
            toplam_q <= toplam_n;
            odenen_q <= odenen_n;
            ustu_q   <= ustu_n;
            sayi_q   <= sayi_n;
            bekle_q  <= bekle_n;
            tamam_q  <= tamam_n;
            iade_q   <= iade_n;
            hata_q   <= hata_n;
        end
    end

    assign kasa.toplam       = toplam_q;
    assign kasa.bavul_sayisi = sayi_q;
    assign kasa.odeme_bekle  = bekle_q;
    assign kasa.para_ustu    = ustu_q;
    assign kasa.tamam        = tamam_q;
    assign kasa.iade         = iade_q;
    assign kasa.hata         = hata_q;
endmodule

// File: tb/tb_bavul_kasa.sv
// tb/tb_bavul_kasa.sv - self-checking bench for bavul_kasa
module tb_bavul_kasa;
    localparam int MAKS  = 8;
    localparam int W     = 12;
    localparam int TAVAN = (1 << W) - 1;

    logic saat  = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int failures = 0;

    bavul_kasa_if #(.TOPLAM_W(W)) kasa ();

    bavul_kasa #(.MAKS_BAVUL(MAKS), .TOPLAM_W(W)) dut (
        .saat  (saat),
        .reset (reset),
        .kasa  (kasa)
    );

    always #5 saat = ~saat;

    task automatic kontrol(input string ad, input int gercek, input int beklenen);
        checks++;
        if (gercek != beklenen) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", ad, gercek, beklenen, $time);
        end
    endtask

    // Passenger-level model: bags collected, coins paid, pending result kind.
    int m_toplam = 0, m_bags = 0, m_paid = 0, m_ustu = 0, m_finish = 0;
    bit m_collect = 0, m_paying = 0, m_tamam = 0, m_iade = 0, m_hata = 0;

    initial begin
        forever begin
            @(posedge saat or negedge reset);
            if (!reset) begin
                m_toplam = 0; m_bags = 0; m_paid = 0; m_ustu = 0; m_finish = 0;
                m_collect = 0; m_paying = 0; m_tamam = 0; m_iade = 0; m_hata = 0;
            end else begin
                m_tamam = 0; m_iade = 0; m_hata = 0;
                if (m_finish != 0) begin
                    m_hata = kasa.bitti;
                    if (m_finish == 1) begin
                        m_tamam = 1;
                        m_ustu  = m_paid - m_toplam;
                    end else begin
                        m_iade = 1;
                        m_ustu = m_paid;
                    end
                    m_toplam = 0; m_bags = 0; m_paid = 0; m_finish = 0; m_collect = 0;
                end else if (m_paying) begin
                    m_hata = kasa.bitti;
                    if (kasa.iptal) begin
                        m_finish = 2; m_paying = 0;
                    end else begin
                        if (kasa.para_gecerli)
                            m_paid = (m_paid + int'(kasa.para) > TAVAN) ? TAVAN : m_paid + int'(kasa.para);
                        if (m_paid >= m_toplam) begin
                            m_finish = 1; m_paying = 0;
                        end
                    end
                end else if (m_collect) begin
                    if (kasa.bitti) begin
                        if (m_bags < MAKS) begin
                            m_bags   = m_bags + 1;
                            m_toplam = m_toplam + int'(kasa.ucret);
                            if (m_toplam > TAVAN) begin
                                m_toplam = TAVAN; m_hata = 1;
                            end
                        end else begin
                            m_hata = 1;
                        end
                    end
                    if (kasa.yolcu_bitti) m_paying = 1;
                end else if (kasa.bitti) begin
                    m_toplam = int'(kasa.ucret); m_bags = 1; m_collect = 1;
                end
            end
            #1;
            kontrol("toplam",       int'(kasa.toplam),       m_toplam);
            kontrol("bavul_sayisi", int'(kasa.bavul_sayisi), m_bags);
            kontrol("odeme_bekle",  int'(kasa.odeme_bekle),  int'(m_paying));
            kontrol("para_ustu",    int'(kasa.para_ustu),    m_ustu);
            kontrol("tamam",        int'(kasa.tamam),        int'(m_tamam));
            kontrol("iade",         int'(kasa.iade),         int'(m_iade));
            kontrol("hata",         int'(kasa.hata),         int'(m_hata));
        end
    end

    task automatic adim(input logic b, input int u, input logic yb,
                        input logic pg, input int p, input logic ip);
        @(negedge saat);
        kasa.bitti        = b;
        kasa.ucret        = 8'(u);
        kasa.yolcu_bitti  = yb;
        kasa.para_gecerli = pg;
        kasa.para         = 8'(p);
        kasa.iptal        = ip;
        @(posedge saat);
        #2;
    endtask

    task automatic bos();
        adim(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic hepsi_sifir(input string ad);
        kontrol({ad, "_toplam"}, int'(kasa.toplam), 0);
        kontrol({ad, "_bavul"},  int'(kasa.bavul_sayisi), 0);
        kontrol({ad, "_bekle"},  int'(kasa.odeme_bekle), 0);
        kontrol({ad, "_ustu"},   int'(kasa.para_ustu), 0);
        kontrol({ad, "_tamam"},  int'(kasa.tamam), 0);
        kontrol({ad, "_iade"},   int'(kasa.iade), 0);
        kontrol({ad, "_hata"},   int'(kasa.hata), 0);
    endtask

    initial begin
        kasa.bitti = 1'b0; kasa.ucret = 8'd0; kasa.yolcu_bitti = 1'b0;
        kasa.para_gecerli = 1'b0; kasa.para = 8'd0; kasa.iptal = 1'b0;
        repeat (3) @(posedge saat);
        #2;
        hepsi_sifir("reset");
        @(negedge saat);
        reset = 1'b1;

        // 1: three bags, a coin while collecting (ignored), then passenger done
        adim(1'b1, 45, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b1, 101, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b1, 51, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b0, 0, 1'b0, 1'b1, 200, 1'b0);
        kontrol("t1_coin_ignored", int'(kasa.toplam), 197);
        adim(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        kontrol("t1_toplam", int'(kasa.toplam), 197);
        kontrol("t1_bavul",  int'(kasa.bavul_sayisi), 3);
        kontrol("t1_bekle",  int'(kasa.odeme_bekle), 1);

        // 2: two coins of 100 cover 197, change 3 two edges later
        adim(1'b0, 0, 1'b0, 1'b1, 100, 1'b0);
        kontrol("t2_tamam_early", int'(kasa.tamam), 0);
        adim(1'b0, 0, 1'b0, 1'b1, 100, 1'b0);
        kontrol("t2_bekle_off", int'(kasa.odeme_bekle), 0);
        kontrol("t2_tamam_not_yet", int'(kasa.tamam), 0);
        bos();
        kontrol("t2_tamam", int'(kasa.tamam), 1);
        kontrol("t2_ustu",  int'(kasa.para_ustu), 3);
        kontrol("t2_toplam_clr", int'(kasa.toplam), 0);
        bos();
        kontrol("t2_tamam_pulse", int'(kasa.tamam), 0);
        kontrol("t2_ustu_held", int'(kasa.para_ustu), 3);

        // 3: nine bags of 5, only the ninth rejected
        for (int i = 0; i < 9; i++) begin
            adim(1'b1, 5, 1'b0, 1'b0, 0, 1'b0);
            kontrol("t3_hata", int'(kasa.hata), (i == 8) ? 1 : 0);
        end
        kontrol("t3_toplam", int'(kasa.toplam), 40);
        kontrol("t3_bavul",  int'(kasa.bavul_sayisi), 8);
        adim(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        adim(1'b1, 9, 1'b0, 1'b0, 0, 1'b0);
        kontrol("t3_odeme_bag_hata", int'(kasa.hata), 1);
        kontrol("t3_odeme_bag_drop", int'(kasa.toplam), 40);
        adim(1'b0, 0, 1'b0, 1'b1, 7, 1'b1);
        bos();
        kontrol("t3_iade", int'(kasa.iade), 1);
        kontrol("t3_iptal_wins", int'(kasa.para_ustu), 0);

        // 4: 198 due, 50 paid, cancel refunds 50
        adim(1'b1, 198, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        adim(1'b0, 0, 1'b0, 1'b1, 50, 1'b0);
        kontrol("t4_toplam", int'(kasa.toplam), 198);
        kontrol("t4_bekle",  int'(kasa.odeme_bekle), 1);
        adim(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        bos();
        kontrol("t4_iade",  int'(kasa.iade), 1);
        kontrol("t4_ustu",  int'(kasa.para_ustu), 50);
        kontrol("t4_tamam", int'(kasa.tamam), 0);

        // 5: zero-fee bags, last one with yolcu_bitti; completes with no coin
        adim(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
        kontrol("t5_bekle", int'(kasa.odeme_bekle), 1);
        kontrol("t5_bavul", int'(kasa.bavul_sayisi), 2);
        bos();
        kontrol("t5_sonuc_bekle", int'(kasa.odeme_bekle), 0);
        adim(1'b1, 77, 1'b0, 1'b0, 0, 1'b0);
        kontrol("t5_tamam", int'(kasa.tamam), 1);
        kontrol("t5_ustu",  int'(kasa.para_ustu), 0);
        kontrol("t5_sonuc_hata", int'(kasa.hata), 1);
        kontrol("t5_bag_dropped", int'(kasa.bavul_sayisi), 0);

        // 6: reset between edges in the middle of a payment
        adim(1'b1, 100, 1'b0, 1'b0, 0, 1'b0);
        adim(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        adim(1'b0, 0, 1'b0, 1'b1, 30, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        hepsi_sifir("t6_async");
        @(negedge saat);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bos();
            kontrol("t6_no_tamam", int'(kasa.tamam), 0);
            kontrol("t6_no_iade",  int'(kasa.iade), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
